// File: rtl/vit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vit_pkg
// Description : Shared FSM state encoding and address/counter widths for the
//               ViT patch packer.
// Revision    : 1.0 - initial release
// ============================================================================
package vit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } vit_state_t;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   // Byte stride between horizontally adjacent packed words.
   function automatic logic [ADDR_W-1:0] word_bytes(input int ow);
      return ADDR_W'(ow / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vit_pack_buf.sv
`default_nettype none
// ============================================================================
// Module      : vit_pack_buf
// Description : Single packing buffer: gathers up to KX channel-padded pixels
//               into one output word and holds it until popped.
// Revision    : 1.0 - initial release
// ============================================================================
module vit_pack_buf
   import vit_pkg::*;
#(
   parameter int DW     = 8,
   parameter int CH_IN  = 3,
   parameter int CH_EXP = 4,
   parameter int KX     = 16,
   parameter int OW     = DW * CH_EXP * KX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                push,
   input  logic                eol,
   input  logic [DW*CH_IN-1:0] pix,
   input  logic [ADDR_W-1:0]   addr_in,
   input  logic                pop,
   output logic [OW-1:0]       data,
   output logic [ADDR_W-1:0]   addr,
   output logic                full,
   output logic                closing
);

   localparam int c_slot_w = DW * CH_EXP;
   localparam int c_ptr_w  = (KX > 1) ? $clog2(KX) : 1;

   logic [c_ptr_w-1:0]  r_ptr;
   logic [OW-1:0]       r_data;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_full;
   logic [c_slot_w-1:0] w_slot;

   // Zero-extension leaves the padding channels at zero.
   assign w_slot  = c_slot_w'(pix);
   assign closing = push && ((r_ptr == c_ptr_w'(KX - 1)) || eol);

   assign data = r_data;
   assign addr = r_addr;
   assign full = r_full;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_ptr  <= '0;
         r_data <= '0;
         r_addr <= '0;
         r_full <= 1'b0;
      end else begin
         // Popping zero-clears so the next fill starts with empty slots.
         if (pop) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_addr <= '0;
         end
         if (push) begin
            r_data[r_ptr*c_slot_w +: c_slot_w] <= w_slot;
            if (closing) begin
               r_ptr  <= '0;
               r_full <= 1'b1;
               r_addr <= addr_in;
            end else begin
               r_ptr <= r_ptr + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vit_patch_packer.sv
`default_nettype none
// ============================================================================
// Module      : vit_patch_packer
// Description : Packs raster-order pixels into KX-pixel patch words with
//               destination addresses, using a ping-pong pair of buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module vit_patch_packer
   import vit_pkg::*;
#(
   parameter int DW     = 8,
   parameter int CH_IN  = 3,
   parameter int CH_EXP = 4,
   parameter int KX     = 16,
   parameter int OW     = DW * CH_EXP * KX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CNT_W-1:0]    cfg_win,
   input  logic [CNT_W-1:0]    cfg_hin,
   input  logic [ADDR_W-1:0]   cfg_base,
   input  logic [ADDR_W-1:0]   cfg_line_stride,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DW*CH_IN-1:0] s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [OW-1:0]       m_data,
   output logic [ADDR_W-1:0]   m_addr,
   output logic                busy,
   output logic                done
);

   localparam logic [ADDR_W-1:0] c_word_bytes = word_bytes(OW);

   vit_state_t        r_state;
   logic [CNT_W-1:0]  r_win;
   logic [CNT_W-1:0]  r_hin;
   logic [CNT_W-1:0]  r_col;
   logic [CNT_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_stride;
   logic [ADDR_W-1:0] r_row_addr;
   logic [ADDR_W-1:0] r_word_addr;
   logic              r_wr_sel;
   logic              r_rd_sel;
   logic              r_busy;
   logic              r_done;

   logic              w_start;
   logic              w_hs;
   logic              w_out_hs;
   logic              w_eol;
   logic              w_last;
   logic              w_close;
   logic              w_push    [2];
   logic              w_pop     [2];
   logic              w_full    [2];
   logic              w_closing [2];
   logic [OW-1:0]     w_data    [2];
   logic [ADDR_W-1:0] w_addr    [2];

   assign w_start  = (r_state == ST_IDLE) && start;
   assign s_ready  = (r_state == ST_RUN) && !w_full[r_wr_sel];
   assign w_hs     = s_valid && s_ready;
   assign m_valid  = w_full[r_rd_sel];
   assign m_data   = w_data[r_rd_sel];
   assign m_addr   = w_addr[r_rd_sel];
   assign w_out_hs = m_valid && m_ready;
   assign w_eol    = (r_col == r_win - CNT_W'(1));
   assign w_last   = w_eol && (r_row == r_hin - CNT_W'(1));
   assign w_close  = w_closing[r_wr_sel];
   assign busy     = r_busy;
   assign done     = r_done;

   for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      assign w_push[gi] = w_hs && (r_wr_sel == 1'(gi));
      assign w_pop[gi]  = w_out_hs && (r_rd_sel == 1'(gi));

      vit_pack_buf #(
         .DW     (DW),
         .CH_IN  (CH_IN),
         .CH_EXP (CH_EXP),
         .KX     (KX),
         .OW     (OW)
      ) u_buf (
         .clk     (clk),
         .rst     (rst),
         .clr     (w_start),
         .push    (w_push[gi]),
         .eol     (w_eol),
         .pix     (s_data),
         .addr_in (r_word_addr),
         .pop     (w_pop[gi]),
         .data    (w_data[gi]),
         .addr    (w_addr[gi]),
         .full    (w_full[gi]),
         .closing (w_closing[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_win       <= '0;
         r_hin       <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_stride    <= '0;
         r_row_addr  <= '0;
         r_word_addr <= '0;
         r_wr_sel    <= 1'b0;
         r_rd_sel    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_win       <= cfg_win;
                  r_hin       <= cfg_hin;
                  r_stride    <= cfg_line_stride;
                  r_row_addr  <= cfg_base;
                  r_word_addr <= cfg_base;
                  r_col       <= '0;
                  r_row       <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_hs) begin
                  if (w_eol) begin
                     r_col <= '0;
                     r_row <= r_row + CNT_W'(1);
                  end else begin
                     r_col <= r_col + CNT_W'(1);
                  end
                  // Address tracks the word being filled; rows restart from row base.
                  if (w_close) begin
                     if (w_eol) begin
                        r_row_addr  <= r_row_addr + r_stride;
                        r_word_addr <= r_row_addr + r_stride;
                     end else begin
                        r_word_addr <= r_word_addr + c_word_bytes;
                     end
                  end
                  if (w_last) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!w_full[0] && !w_full[1]) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         if (w_out_hs) begin
            r_rd_sel <= ~r_rd_sel;
         end
         if (w_close) begin
            r_wr_sel <= ~r_wr_sel;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vit_patch_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vit_patch_packer
// Description : Scoreboard bench for vit_patch_packer with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vit_patch_packer;

   localparam int DW     = 8;
   localparam int CH_IN  = 3;
   localparam int CH_EXP = 4;
   localparam int KX     = 16;
   localparam int OW     = DW * CH_EXP * KX;
   localparam int WB     = OW / 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [15:0]         cfg_win, cfg_hin;
   logic [31:0]         cfg_base, cfg_line_stride;
   logic                s_valid, s_ready;
   logic [DW*CH_IN-1:0] s_data;
   logic                m_valid, m_ready;
   logic [OW-1:0]       m_data;
   logic [31:0]         m_addr;
   logic                busy, done;

   vit_patch_packer #(.DW(DW), .CH_IN(CH_IN), .CH_EXP(CH_EXP), .KX(KX), .OW(OW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_win(cfg_win), .cfg_hin(cfg_hin), .cfg_base(cfg_base), .cfg_line_stride(cfg_line_stride),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   logic [OW-1:0] exp_d[$];
   logic [31:0]   exp_a[$];
   int rdy_mode = 1;
   int ignore_out = 0;
   int frame_words = 0;
   int done_cnt = 0;
   int px_sent = 0;
   int stall_thr = 0;
   int saw_block = 0;
   int first_seen = 0;
   logic [OW-1:0] first_word;
   logic          prev_stall = 1'b0;
   logic [OW-1:0] prev_data;
   logic [31:0]   prev_addr;

   task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom % 2);
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Monitor: decisions made at negedge complete on the following posedge.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_data", m_data, prev_data);
            check("hold_addr", OW'({m_valid, m_addr}), OW'({1'b1, prev_addr}));
         end
         if (m_valid && m_ready && ignore_out == 0) begin
            if (exp_d.size() == 0) begin
               check("unexpected_word", OW'(m_addr), '1);
            end else begin
               check("word_data", m_data, exp_d.pop_front());
               check("word_addr", OW'(m_addr), OW'(exp_a.pop_front()));
            end
            frame_words++;
            if (first_seen == 0) begin
               first_word = m_data;
               first_seen = 1;
            end
         end
         if (rdy_mode == 2 && busy && s_valid && !s_ready) saw_block = 1;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_addr  = m_addr;
         if (done) done_cnt++;
      end
   end

   // pat: 0 random, 1 raster index, 2 random with pixel(0,0)=0x030201
   task automatic run_frame(input int win, input int hin, input logic [31:0] base,
                            input logic [31:0] stride, input int pat, input int vrand,
                            input int stall_at, input int inject_at, input int abort_after);
      logic [23:0]   pix[$];
      logic [OW-1:0] w;
      int n, nw, dc0, cyc, idx, inj;
      n  = win * hin;
      nw = (win + KX - 1) / KX;
      for (int i = 0; i < n; i++) pix.push_back(pat == 1 ? 24'(i) : 24'($urandom));
      if (pat == 2) pix[0] = 24'h030201;
      if (abort_after < 0) begin
         for (int r = 0; r < hin; r++) begin
            for (int k = 0; k < nw; k++) begin
               w = '0;
               for (int j = 0; j < KX; j++) begin
                  if (k * KX + j < win) w[j*32 +: 24] = pix[r*win + k*KX + j];
               end
               exp_d.push_back(w);
               exp_a.push_back(base + 32'(r) * stride + 32'(k * WB));
            end
         end
      end
      ignore_out  = (abort_after >= 0) ? 1 : 0;
      frame_words = 0;
      first_seen  = 0;
      saw_block   = 0;
      px_sent     = 0;
      dc0         = done_cnt;
      @(posedge clk); #1;
      cfg_win = 16'(win); cfg_hin = 16'(hin); cfg_base = base; cfg_line_stride = stride;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (stall_at >= 0) begin
         stall_thr = stall_at;
         fork
            begin
               wait (px_sent >= stall_thr);
               rdy_mode = 2;
               repeat (100) @(posedge clk);
               #1 rdy_mode = 0;
            end
         join_none
      end
      idx = 0; cyc = 0; inj = 0;
      while (idx < n && !(abort_after >= 0 && idx >= abort_after)) begin
         if (cyc > n * 20 + 2000) begin
            check("pixel_timeout", OW'(idx), OW'(n));
            break;
         end
         s_valid = (vrand != 0) ? ($urandom % 4 != 0) : 1'b1;
         s_data  = pix[idx];
         if (idx == inject_at && inj == 0) begin
            start = 1'b1; cfg_win = 16'd3; cfg_hin = 16'd5; cfg_base = 32'h0; inj = 1;
         end
         @(negedge clk);
         if (s_valid && s_ready) idx++;
         px_sent = idx;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      s_valid = 1'b0;
      if (abort_after < 0) begin
         cyc = 0;
         while (done_cnt == dc0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
         end
         repeat (3) @(negedge clk);
         check("done_pulses", OW'(done_cnt - dc0), OW'(1));
         check("word_count", OW'(frame_words), OW'(nw * hin));
         check("queue_empty", OW'(exp_d.size()), OW'(0));
         check("busy_after", OW'(busy), OW'(0));
         if (pat == 2) check("first_pixel", OW'(first_word[31:0]), OW'(32'h00030201));
         if (stall_at >= 0) check("s_ready_blocked", OW'(saw_block), OW'(1));
      end
   endtask

   initial begin
      int bad;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      cfg_win = '0; cfg_hin = '0; cfg_base = '0; cfg_line_stride = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", OW'(s_ready), OW'(0));
      check("rst_m_valid", OW'(m_valid), OW'(0));
      check("rst_m_data", m_data, '0);
      check("rst_m_addr", OW'(m_addr), OW'(0));
      check("rst_busy", OW'(busy), OW'(0));
      check("rst_done", OW'(done), OW'(0));
      @(posedge clk); #1 rst = 1'b0;

      rdy_mode = 1;
      run_frame(20, 2, 32'h0000_1000, 32'h0000_0200, 2, 1, -1, -1, -1);
      run_frame(37, 3, 32'hFFFF_FFC0, 32'h0000_0100, 0, 1, -1, -1, -1);
      run_frame(1, 3, 32'h0000_0040, 32'h0000_0080, 0, 1, -1, -1, -1);
      run_frame(16, 2, 32'h8000_0000, 32'h0000_0040, 0, 1, -1, -1, -1);
      rdy_mode = 0;
      run_frame(64, 4, 32'h0010_0000, 32'h0000_0400, 0, 0, 10, -1, -1);
      rdy_mode = 1;
      run_frame(40, 3, 32'h0002_0000, 32'h0000_0300, 0, 1, -1, 30, -1);

      run_frame(40, 4, 32'h0003_0000, 32'h0000_0200, 0, 0, -1, -1, 50);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ignore_out = 0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_valid || busy) bad = 1;
      end
      check("quiet_after_rst", OW'(bad), OW'(0));
      run_frame(16, 1, 32'h0004_0000, 32'h0000_0040, 0, 1, -1, -1, -1);

      rdy_mode = 0;
      run_frame(224, 224, 32'h0, 32'd896, 1, 0, -1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/vit_patch_packer.md
VIT_PATCH_PACKER -- requirements
Module: vit_patch_packer

Interface
REQ-001 SHALL have parameter DW, default 8, bits per channel sample.
REQ-002 SHALL have parameter CH_IN, default 3, real input channels per pixel.
REQ-003 SHALL have parameter CH_EXP, default 4, padded channels per pixel; CH_EXP >= CH_IN.
REQ-004 SHALL have parameter KX, default 16, pixels per packed word (patch width).
REQ-005 SHALL have parameter OW = DW*CH_EXP*KX, default 512, output word width.
REQ-006 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: start  in  1  one-cycle pulse; latches cfg_* and begins a frame.
REQ-009 SHALL have ports: cfg_win  in  16  pixels per row (>=1); cfg_hin  in  16  rows (>=1).
REQ-010 SHALL have ports: cfg_base  in  32  byte address of word (0,0); cfg_line_stride  in  32  bytes per row.
REQ-011 SHALL have ports: s_valid  in  1; s_ready  out  1; s_data  in  DW*CH_IN  pixel, channel c at bits [c*DW +: DW].
REQ-012 SHALL have ports: m_valid  out  1; m_ready  in  1; m_data  out  OW; m_addr  out  32  destination byte address.
REQ-013 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse after last word accepted.

Function
REQ-014 SHALL accept pixels raster order (row-major, left to right) on s_valid&s_ready handshakes.
REQ-015 SHALL place column-in-word j at bits [j*CH_EXP*DW +: CH_EXP*DW]; channel c of that pixel at offset c*DW; channels CH_IN..CH_EXP-1 zero.
REQ-016 SHALL close a word after KX pixels or at the last pixel of a row; unfilled pixel slots zero.
REQ-017 SHALL compute m_addr = cfg_base + row*cfg_line_stride + k*(OW/8), k = word index within row, using latched cfg values.
REQ-018 SHALL use two packing buffers (ping-pong): one filling, one presenting; s_ready=0 only when both are full or state not RUN.
REQ-019 SHALL hold m_data/m_addr stable while m_valid=1 and m_ready=0.
REQ-020 SHALL give latency from closing handshake of a word to m_valid=1 of exactly 1 cycle when the output buffer is free.
REQ-021 SHALL permit a closing input handshake and an output handshake in the same cycle without stall or loss.
REQ-022 SHALL have FSM IDLE -> RUN on start; RUN -> DRAIN after last pixel (row cfg_hin-1, col cfg_win-1) accepted; DRAIN -> DONE when all words accepted; DONE -> IDLE next cycle.
REQ-023 SHALL assert done for exactly the DONE cycle; busy=1 in RUN and DRAIN.
REQ-024 SHALL ignore start outside IDLE; SHALL drive s_ready=0 in IDLE, DRAIN, DONE.
REQ-025 SHALL emit ceil(cfg_win/KX)*cfg_hin words per frame.
REQ-026 SHALL maintain column counter wrap at cfg_win-1 to 0 with row increment; word counter wrap per row.
REQ-027 SHALL compute address arithmetic in 32 bits, wrapping modulo 2^32.

Reset
REQ-028 SHALL on rst=1 set state IDLE, both buffers empty and zeroed, counters 0, s_ready=0, m_valid=0, m_data=0, m_addr=0, busy=0, done=0.
REQ-029 SHALL abandon any in-flight frame on reset mid-operation with no further m_valid until next start.
REQ-030 SHALL give rst priority over start in the same cycle.

Structure
REQ-031 SHALL place FSM state enum and address-calc widths in shared package vit_pkg.
REQ-032 SHALL contain one sub-module vit_pack_buf (single packing buffer with fill pointer, full flag, zero-clear), instantiated twice.

Verification
REQ-033 Win=224,Hin=224,base=0,stride=896, pixel(i,j)=i*224+j low bits -> 3136 words, word(i,k) at i*896+k*64, done once.
REQ-034 Win=20,KX=16,Hin=2 -> 4 words; words k=1 have pixels 4..15 all zero; addresses base, base+64, base+stride, base+stride+64.
REQ-035 m_ready held 0 for 100 cycles mid-frame -> s_ready drops after two buffers fill; m_data/m_addr unchanged; no pixel lost.
REQ-036 pixel (0,0)=0x030201 -> m_data[31:0]=0x00030201 (pad channel zero).
REQ-037 rst pulsed after 50 pixels, then start Win=16,Hin=1 -> exactly 1 word, no stale data, done pulses once.
REQ-038 start pulsed while busy -> ignored; word count and cfg unchanged.
